// File: rtl/nrisc_mem_responder.sv
// nrisc_mem_responder
// Memory-side responder for the 8-bit nRisc core. One single-ported byte
// array serves three clients:
//   - an instruction-fetch port (1-cycle registered read),
//   - a data port with a wait-state FSM and a completion pulse,
//   - a load port that fills the array before the core runs.
// Data accesses take priority over fetch, and the load port takes priority
// over accepting a new data access.
//
// Data handshake: the core raises LerMem and/or EscMem with a stable
// EnderecoDado/DadoEscrita and holds them until DadoPronto is seen. The
// request is accepted on an edge where the FSM is IDLE and CargaEn is low.
// DadoPronto is a one-cycle pulse, and LeDado is valid while it is high.
// Ocupado is high while the access is in flight (WAIT, ACCESS). If LerMem
// and EscMem are high together, the access is a write and ErroAcesso pulses
// once.
//
// Ports:
//   Clock, reset            clock, asynchronous active-high reset
//   EnderecoInst            fetch address (core PC)
//   Instrucao, InstValida   fetched byte, valid flag (mem[addr of prev edge])
//   EnderecoDado            data address
//   DadoEscrita             write data
//   LerMem, EscMem          read / write request
//   LeDado                  read data
//   DadoPronto              one-cycle completion pulse
//   Ocupado                 access in flight (core freezes its PC)
//   ErroAcesso              one-cycle pulse on simultaneous LerMem/EscMem
//   CargaEn                 load-port write strobe
//   CargaEnd, CargaDado     load-port address and data
//   estado_dbg              current data FSM state, for observation
module nrisc_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] EnderecoInst,
  output logic [7:0]        Instrucao,
  output logic              InstValida,
  input  logic [ADDR_W-1:0] EnderecoDado,
  input  logic [7:0]        DadoEscrita,
  input  logic              LerMem,
  input  logic              EscMem,
  output logic [7:0]        LeDado,
  output logic              DadoPronto,
  output logic              Ocupado,
  output logic              ErroAcesso,
  input  logic              CargaEn,
  input  logic [ADDR_W-1:0] CargaEnd,
  input  logic [7:0]        CargaDado,
  output logic [1:0]        estado_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;
  // Counter preset on acceptance. WAIT leaves for ACCESS when it reads 0,
  // so WAIT_CYCLES-1 gives exactly WAIT_CYCLES cycles spent in WAIT.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [7:0]        mem [DEPTH];
  state_t            state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              wr_q;
  logic              accept;

  // The load port has priority. While it is writing, a pending data
  // request stays unaccepted and the core keeps holding it.
  assign accept     = (state == S_IDLE) && (LerMem || EscMem) && !CargaEn;
  assign estado_dbg = state;

  // Array writes. This block has no reset, so the contents survive a reset.
  // The !reset gate drops a write that would coincide with reset. A write
  // aborted by reset never reaches ACCESS, because reset forces IDLE.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      if (state == S_ACCESS && wr_q) begin
        mem[addr_q] <= data_q;
      end else if (state == S_IDLE && CargaEn) begin
        mem[CargaEnd] <= CargaDado;
      end
    end
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= 4'd0;
      addr_q     <= '0;
      data_q     <= 8'd0;
      wr_q       <= 1'b0;
      Instrucao  <= 8'd0;
      InstValida <= 1'b0;
      LeDado     <= 8'd0;
      DadoPronto <= 1'b0;
      Ocupado    <= 1'b0;
      ErroAcesso <= 1'b0;
    end else begin
      DadoPronto <= 1'b0;
      ErroAcesso <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q     <= EnderecoDado;
            data_q     <= DadoEscrita;
            wr_q       <= EscMem;  // a simultaneous read and write becomes a write
            ErroAcesso <= LerMem && EscMem;
            wait_cnt   <= WAIT_LOAD;
            Ocupado    <= 1'b1;
            InstValida <= 1'b0;
            state      <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
          end else if (CargaEn) begin
            // The array port is busy with the load write, so Instrucao holds.
            InstValida <= 1'b0;
          end else begin
            Instrucao  <= mem[EnderecoInst];
            InstValida <= 1'b1;
          end
        end
        S_WAIT: begin
          InstValida <= 1'b0;
          if (wait_cnt == 4'd0) begin
            state <= S_ACCESS;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          InstValida <= 1'b0;
          if (!wr_q) begin
            LeDado <= mem[addr_q];
          end
          DadoPronto <= 1'b1;
          // Ocupado drops together with the DadoPronto pulse, so the core
          // can advance on the edge that ends RESP.
          Ocupado    <= 1'b0;
          state      <= S_RESP;
        end
        S_RESP: begin
          InstValida <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nrisc_mem_responder.sv
// Bench for nrisc_mem_responder. Two instances share one clock:
//   index 0: WAIT_CYCLES=1
//   index 1: WAIT_CYCLES=0
// The reference model is a plain byte array per instance, updated by each
// load and write. Expected latencies come from the documented timing.
module tb_nrisc_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst         [2];
  logic [7:0] ende_inst   [2];
  logic [7:0] instrucao   [2];
  logic       inst_valida [2];
  logic [7:0] ende_dado   [2];
  logic [7:0] dado_esc    [2];
  logic       ler         [2];
  logic       esc         [2];
  logic [7:0] le_dado     [2];
  logic       dado_pronto [2];
  logic       ocupado     [2];
  logic       erro_acesso [2];
  logic       carga_en    [2];
  logic [7:0] carga_end   [2];
  logic [7:0] carga_dado  [2];
  logic [1:0] estado      [2];

  logic [7:0] ref_mem [2][256];
  int chk_cnt = 0;
  int err_cnt = 0;

  nrisc_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut_a (
    .Clock(clk), .reset(rst[0]),
    .EnderecoInst(ende_inst[0]), .Instrucao(instrucao[0]), .InstValida(inst_valida[0]),
    .EnderecoDado(ende_dado[0]), .DadoEscrita(dado_esc[0]),
    .LerMem(ler[0]), .EscMem(esc[0]), .LeDado(le_dado[0]),
    .DadoPronto(dado_pronto[0]), .Ocupado(ocupado[0]), .ErroAcesso(erro_acesso[0]),
    .CargaEn(carga_en[0]), .CargaEnd(carga_end[0]), .CargaDado(carga_dado[0]),
    .estado_dbg(estado[0])
  );

  nrisc_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
    .Clock(clk), .reset(rst[1]),
    .EnderecoInst(ende_inst[1]), .Instrucao(instrucao[1]), .InstValida(inst_valida[1]),
    .EnderecoDado(ende_dado[1]), .DadoEscrita(dado_esc[1]),
    .LerMem(ler[1]), .EscMem(esc[1]), .LeDado(le_dado[1]),
    .DadoPronto(dado_pronto[1]), .Ocupado(ocupado[1]), .ErroAcesso(erro_acesso[1]),
    .CargaEn(carga_en[1]), .CargaEnd(carga_end[1]), .CargaDado(carga_dado[1]),
    .estado_dbg(estado[1])
  );

  function automatic int wc(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int d, input logic [7:0] a, input logic [7:0] v);
    @(posedge clk); #1;
    carga_en[d] = 1'b1; carga_end[d] = a; carga_dado[d] = v;
    @(posedge clk); #1;
    carga_en[d] = 1'b0;
    ref_mem[d][a] = v;
  endtask

  task automatic fetch(input int d, input logic [7:0] a, input string tag);
    @(posedge clk); #1;
    ende_inst[d] = a;
    @(posedge clk); #1;
    check({tag, "_instr"}, {24'd0, instrucao[d]}, {24'd0, ref_mem[d][a]});
    check({tag, "_ivalid"}, {31'd0, inst_valida[d]}, 32'd1);
  endtask

  // One complete data access. Latency is counted in edges from the edge
  // that first sees the request to the sample in which DadoPronto is high.
  task automatic access(input int d, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] wd, input string tag);
    int lat, ocup, erro, ibad;
    logic [7:0] rdata, exp_rd;
    bit done;
    lat = 0; ocup = 0; erro = 0; ibad = 0; rdata = 8'd0; done = 1'b0;
    exp_rd = ref_mem[d][a];
    @(posedge clk); #1;
    ler[d] = rd; esc[d] = wr; ende_dado[d] = a; dado_esc[d] = wd;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ocupado[d]) begin
        ocup++;
        if (inst_valida[d]) ibad++;
      end
      if (erro_acesso[d]) erro++;
      if (dado_pronto[d]) begin
        done = 1'b1;
        rdata = le_dado[d];
      end
    end
    ler[d] = 1'b0; esc[d] = 1'b0;
    check({tag, "_lat"}, lat, wc(d) + 2);
    check({tag, "_ocup"}, ocup, wc(d) + 1);
    check({tag, "_erro"}, erro, (rd && wr) ? 1 : 0);
    check({tag, "_ivalid_busy"}, ibad, 0);
    if (wr) ref_mem[d][a] = wd;
    else check({tag, "_rdata"}, {24'd0, rdata}, {24'd0, exp_rd});
  endtask

  initial begin
    int lat, npr;
    logic [7:0] rdata, a, v;
    int op;
    bit done;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; ende_inst[d] = 8'd0; ende_dado[d] = 8'd0; dado_esc[d] = 8'd0;
      ler[d] = 1'b0; esc[d] = 1'b0; carga_en[d] = 1'b0; carga_end[d] = 8'd0;
      carga_dado[d] = 8'd0;
    end
    #1;
    // Reset state of both instances.
    for (int d = 0; d < 2; d++) begin
      check("rst_instr", {24'd0, instrucao[d]}, 32'd0);
      check("rst_ivalid", {31'd0, inst_valida[d]}, 32'd0);
      check("rst_ledado", {24'd0, le_dado[d]}, 32'd0);
      check("rst_pronto", {31'd0, dado_pronto[d]}, 32'd0);
      check("rst_ocup", {31'd0, ocupado[d]}, 32'd0);
      check("rst_erro", {31'd0, erro_acesso[d]}, 32'd0);
      check("rst_state", {30'd0, estado[d]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Fill both arrays through the load port with random bytes.
    // Address 0x40 gets 0x00.
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        v = (i == 8'h40) ? 8'h00 : 8'($urandom_range(0, 255));
        carga_en[d] = 1'b1; carga_end[d] = 8'(i); carga_dado[d] = v;
        ref_mem[d][i] = v;
      end
    end
    @(posedge clk); #1;
    carga_en[0] = 1'b0; carga_en[1] = 1'b0;

    // Load a byte, then fetch it.
    load(0, 8'h10, 8'hA5);
    fetch(0, 8'h10, "fetch_a5");
    load(1, 8'h10, 8'hA5);
    fetch(1, 8'h10, "fetch_a5_w0");

    // WAIT_CYCLES=1: a write, then a read back from the same address.
    access(0, 1'b0, 1'b1, 8'h20, 8'h3C, "w1_wr20");
    access(0, 1'b1, 1'b0, 8'h20, 8'h00, "w1_rd20");

    // WAIT_CYCLES=0: read the top address.
    load(1, 8'hFF, 8'h7E);
    access(1, 1'b1, 1'b0, 8'hFF, 8'h00, "w0_rdff");

    // Simultaneous read and write is treated as a write.
    access(0, 1'b1, 1'b1, 8'h05, 8'h11, "both05");
    access(0, 1'b1, 1'b0, 8'h05, 8'h00, "rd05");
    fetch(0, 8'h05, "fetch05");

    // Reset while a write to 0x40 is in WAIT.
    @(posedge clk); #1;
    esc[0] = 1'b1; ende_dado[0] = 8'h40; dado_esc[0] = 8'h99;
    @(posedge clk); #1;
    check("abort_in_wait", {30'd0, estado[0]}, 32'd1);
    #2;
    rst[0] = 1'b1;
    #1;
    check("abort_instr", {24'd0, instrucao[0]}, 32'd0);
    check("abort_ivalid", {31'd0, inst_valida[0]}, 32'd0);
    check("abort_pronto", {31'd0, dado_pronto[0]}, 32'd0);
    check("abort_ocup", {31'd0, ocupado[0]}, 32'd0);
    check("abort_erro", {31'd0, erro_acesso[0]}, 32'd0);
    check("abort_state", {30'd0, estado[0]}, 32'd0);
    esc[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    npr = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (dado_pronto[0]) npr++;
    end
    check("abort_no_pronto", npr, 0);
    access(0, 1'b1, 1'b0, 8'h40, 8'h00, "abort_rd40");

    // A load in the same cycle as a read blocks the read for that edge.
    @(posedge clk); #1;
    carga_en[0] = 1'b1; carga_end[0] = 8'h33; carga_dado[0] = 8'h5A;
    ler[0] = 1'b1; ende_dado[0] = 8'h33;
    @(posedge clk); #1;
    check("carga_block_ocup", {31'd0, ocupado[0]}, 32'd0);
    check("carga_block_ivalid", {31'd0, inst_valida[0]}, 32'd0);
    ref_mem[0][8'h33] = 8'h5A;
    carga_en[0] = 1'b0;
    lat = 0; done = 1'b0; rdata = 8'd0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (dado_pronto[0]) begin
        done = 1'b1;
        rdata = le_dado[0];
      end
    end
    ler[0] = 1'b0;
    check("carga_then_rd_lat", lat, 3);
    check("carga_then_rd_data", {24'd0, rdata}, 32'h5A);

    // Random traffic on a small address window, so that reads often
    // follow writes to the same address.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 24; k++) begin
        op = $urandom_range(0, 3);
        a  = 8'(8'h80 + $urandom_range(0, 7));
        v  = 8'($urandom_range(0, 255));
        case (op)
          0: fetch(d, a, "rnd_fetch");
          1: access(d, 1'b1, 1'b0, a, v, "rnd_rd");
          2: access(d, 1'b0, 1'b1, a, v, "rnd_wr");
          default: access(d, 1'b1, 1'b1, a, v, "rnd_both");
        endcase
      end
    end

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
